// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//
// Branch resolution unit with an architectural {Z,V,N} flag register.
// A branch request is accepted in IDLE and evaluated against the flags. A taken
// branch produces a one-cycle redirect pulse with the target address, and then
// holds flush high for FLUSH_CYCLES cycles. While flush is high, new branches
// are ignored and ALU flag writes are squashed.
//
// Configuration macro: BR_FLAG_BYPASS_EN
//   defined   : if an ALU result writes the flags in the same cycle as an
//               accepted branch, the branch is evaluated against the bypassed
//               next-flag value. This adds no latency.
//   undefined : in that case the request is latched. The FSM spends one cycle
//               in HOLD and evaluates the updated flags_q.
//
// Parameters
//   FLUSH_CYCLES  number of flush cycles after a taken branch (1..7)
//
// Ports
//   clk          in   clock; all state updates on the rising edge
//   rst          in   asynchronous, active-high reset
//   alu_valid    in   ALU result in flight this cycle
//   alu_op       in   ALU opcode (selects which flags are written)
//   alu_flags    in   ALU flags {Z,V,N}
//   br_valid     in   branch request, held until br_ready
//   br_reg       in   0 = PC-relative (B), 1 = register target (BR)
//   br_cond      in   condition code
//   pc_plus2     in   branch address + 2
//   imm9         in   signed word offset
//   reg_target   in   BR target address
//   br_ready     out  the request is accepted when br_valid is also 1
//   redirect     out  one-cycle pulse for a taken branch
//   target       out  taken-branch address; holds until the next redirect
//   flush        out  squash the wrong-path instructions
//   flags_q      out  architectural flags {Z,V,N}
// -----------------------------------------------------------------------------
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  alu_flags,
    input  logic        br_valid,
    input  logic        br_reg,
    input  logic [2:0]  br_cond,
    input  logic [15:0] pc_plus2,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_target,
    output logic        br_ready,
    output logic        redirect,
    output logic [15:0] target,
    output logic        flush,
    output logic [2:0]  flags_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  flags_d;
    logic        redirect_q, redirect_d;
    logic [15:0] target_q, target_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        wr_all;     // opcode writes Z, V and N
    logic        wr_z;       // opcode writes Z only
    logic        squash;
    logic [15:0] br_tgt;

`ifndef BR_FLAG_BYPASS_EN
    logic        hazard;
    logic [2:0]  hold_cond_q, hold_cond_d;
    logic [15:0] hold_tgt_q, hold_tgt_d;
`endif

    // Flag layout: [2] Z, [1] V, [0] N.
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (cond)
            3'b000:  cond_met = !z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = !z && !n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = z || (!z && !n);
            3'b101:  cond_met = n || z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    assign wr_all = (alu_op == 4'b0000) || (alu_op == 4'b0001);
    assign wr_z   = (alu_op == 4'b0010) || (alu_op == 4'b0100) ||
                    (alu_op == 4'b0101) || (alu_op == 4'b0110);
    assign squash = (state_q == ST_FLUSH);

    // B target: the word offset is sign-extended and doubled. The sum wraps
    // modulo 2^16.
    assign br_tgt = br_reg ? reg_target
                           : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

`ifndef BR_FLAG_BYPASS_EN
    assign hazard = alu_valid && (wr_all || wr_z);
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so that no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        flags_d    = flags_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        cnt_d      = cnt_q;
`ifndef BR_FLAG_BYPASS_EN
        hold_cond_d = hold_cond_q;
        hold_tgt_d  = hold_tgt_q;
`endif

        // Flag register update. A squashed ALU result does not write the flags.
        if (alu_valid && !squash) begin
            if (wr_all) begin
                flags_d = alu_flags;
            end else if (wr_z) begin
                flags_d[2] = alu_flags[2];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
`ifdef BR_FLAG_BYPASS_EN
                    // flags_d already holds any same-cycle flag write.
                    if (cond_met(br_cond, flags_d)) begin
                        redirect_d = 1'b1;
                        target_d   = br_tgt;
                        cnt_d      = 3'(FLUSH_CYCLES - 1);
                        state_d    = ST_FLUSH;
                    end
`else
                    if (hazard) begin
                        hold_cond_d = br_cond;
                        hold_tgt_d  = br_tgt;
                        state_d     = ST_HOLD;
                    end else if (cond_met(br_cond, flags_q)) begin
                        redirect_d = 1'b1;
                        target_d   = br_tgt;
                        cnt_d      = 3'(FLUSH_CYCLES - 1);
                        state_d    = ST_FLUSH;
                    end
`endif
                end
            end

            ST_HOLD: begin
`ifndef BR_FLAG_BYPASS_EN
                // flags_q now holds the flags written by the hazarding ALU op.
                if (cond_met(hold_cond_q, flags_q)) begin
                    redirect_d = 1'b1;
                    target_d   = hold_tgt_q;
                    cnt_d      = 3'(FLUSH_CYCLES - 1);
                    state_d    = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, so the update does not depend on the
    // order in which the statements are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            flags_q    <= 3'b000;
            redirect_q <= 1'b0;
            target_q   <= 16'h0000;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
        end
    end

`ifndef BR_FLAG_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cond_q <= 3'b000;
            hold_tgt_q  <= 16'h0000;
        end else begin
            hold_cond_q <= hold_cond_d;
            hold_tgt_q  <= hold_tgt_d;
        end
    end
`endif

    assign br_ready = (state_q == ST_IDLE) && !rst;
    assign redirect = redirect_q;
    assign target   = target_q;
    assign flush    = (state_q == ST_FLUSH);

endmodule
